// File: rtl/mmio_bus_interconnect.sv
// Memory-mapped I/O interconnect: decodes a single outstanding CPU load/store
// into a one-hot slave select, waits for the selected slave's ack (bounded by a
// watchdog), then returns a one-cycle response pulse.
module mmio_bus_interconnect #(
  parameter int unsigned                  NUM_SLAVES = 3,
  parameter int unsigned                  ADDR_W     = 32,
  parameter int unsigned                  DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS = {32'h500, 32'h400, 32'h0},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASKS = {32'hFFFFFFF0, 32'hFFFFFFF0,
                                                        32'hFFFFFC00},
  parameter int unsigned                  TIMEOUT    = 15,
  parameter logic [DATA_W-1:0]            ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_err,
  output logic [7:0]                   err_count,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_we,
  output logic                         s_re,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ack
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                err_evt;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [ADDR_W-1:0]   dec_off;

  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;
  logic [NUM_SLAVES-1:0] sel_onehot;

  logic                in_access;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    dec_off = req_addr;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((req_addr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) == BASE_ADDRS[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = i[IDX_W-1:0];
        dec_off = req_addr & ~ADDR_MASKS[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Route ack/read data of the latched slave only; other slaves' acks are ignored.
  always_comb begin
    sel_ack    = 1'b0;
    sel_rdata  = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == i[IDX_W-1:0]) begin
        sel_ack       = s_ack[i];
        sel_rdata     = s_rdata[i*DATA_W +: DATA_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and datapath update for the IDLE -> ACCESS -> RESP sequence.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    err_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = dec_off;
          wdata_d = req_wdata;
          idx_d   = dec_idx;
          cnt_d   = '0;
          if (dec_hit) begin
            state_d = StAccess;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
            err_evt = 1'b1;
          end
        end
      end
      StAccess: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (sel_ack) begin
          state_d = StResp;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : sel_rdata;
        end else if ((TIMEOUT != 0) && ((cnt_q + 32'd1) == TIMEOUT)) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
          err_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    err_cnt_d = (err_evt && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // State and latched transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Outputs decoded from state so strobes drop as soon as reset hits.
  always_comb begin
    in_access  = (state_q == StAccess);
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_err   = resp_valid & err_q;
    resp_rdata = rdata_q;
    err_count  = err_cnt_q;
    s_sel      = in_access ? sel_onehot : '0;
    s_we       = in_access & we_q;
    s_re       = in_access & ~we_q;
    s_addr     = addr_q;
    s_wdata    = wdata_q;
  end

endmodule

// File: tb/tb_mmio_bus_interconnect.sv
// Directed bench for mmio_bus_interconnect: inputs change on the falling edge,
// outputs are sampled on the falling edge, slaves are modelled inline.
module tb_mmio_bus_interconnect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_we;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  err_count;
  logic [2:0]  s_sel;
  logic        s_we, s_re;
  logic [31:0] s_addr, s_wdata;
  logic [95:0] s_rdata;
  logic [2:0]  s_ack;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mmio_bus_interconnect #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .err_count(err_count),
    .s_sel(s_sel), .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  task automatic test_reset;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; s_rdata = '0; s_ack = 0;
    #1 rst = 0;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin miscompares++; $display("FAIL rst_resp: got v=%b e=%b want 0 0", resp_valid, resp_err); end
    vectors++; if (s_sel !== 3'b000 || s_we !== 1'b0 || s_re !== 1'b0) begin miscompares++; $display("FAIL rst_strobes: got sel=%b we=%b re=%b want 000 0 0", s_sel, s_we, s_re); end
    vectors++; if (resp_rdata !== 32'h0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_data: got r=%h a=%h w=%h want 0", resp_rdata, s_addr, s_wdata); end
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL rst_errcnt: got %h want 00", err_count); end
    rst = 1;
  endtask

  // Ack already present in IDLE must be ignored, then completes the 1st ACCESS cycle.
  task automatic test_read_switch;
    req_valid = 1; req_we = 0; req_addr = 32'h404;
    s_rdata = {32'h0, 32'h0000A5A5, 32'h0}; s_ack = 3'b010;
    @(negedge clk);
    req_valid = 0;
    vectors++; if (s_sel !== 3'b010 || s_re !== 1'b1 || s_we !== 1'b0) begin miscompares++; $display("FAIL rd_strobe: got sel=%b re=%b we=%b want 010 1 0", s_sel, s_re, s_we); end
    vectors++; if (s_addr !== 32'h4) begin miscompares++; $display("FAIL rd_addr: got %h want 4", s_addr); end
    vectors++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_busy: got rdy=%b v=%b want 0 0", req_ready, resp_valid); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000A5A5 || resp_err !== 1'b0) begin miscompares++; $display("FAIL rd_resp: got v=%b d=%h e=%b want 1 0000a5a5 0", resp_valid, resp_rdata, resp_err); end
    vectors++; if (s_sel !== 3'b000 || s_re !== 1'b0) begin miscompares++; $display("FAIL rd_resp_strobe: got sel=%b re=%b want 000 0", s_sel, s_re); end
    s_ack = 0;
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rd_idle: got v=%b rdy=%b want 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_write_wait;
    int cnt = 0;
    int early = 0;
    req_valid = 1; req_we = 1; req_addr = 32'h500; req_wdata = 32'hCAFE; s_ack = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 0;
      if (s_we === 1'b1 && s_sel === 3'b100 && s_wdata === 32'hCAFE) cnt++;
      if (resp_valid !== 1'b0) early++;
      if (k == 4) s_ack = 3'b100;
    end
    vectors++; if (cnt != 4) begin miscompares++; $display("FAIL wr_hold: got %0d strobe cycles want 4", cnt); end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL wr_early: got %0d early resp want 0", early); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin miscompares++; $display("FAIL wr_resp: got v=%b d=%h e=%b want 1 0 0", resp_valid, resp_rdata, resp_err); end
    vectors++; if (s_we !== 1'b0) begin miscompares++; $display("FAIL wr_we_drop: got %b want 0", s_we); end
    s_ack = 0;
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_unmapped;
    req_valid = 1; req_we = 0; req_addr = 32'h2000;
    @(negedge clk);
    req_valid = 0;
    vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL um_resp: got v=%b e=%b d=%h want 1 1 deadbeef", resp_valid, resp_err, resp_rdata); end
    vectors++; if (s_sel !== 3'b000 || s_re !== 1'b0) begin miscompares++; $display("FAIL um_strobe: got sel=%b re=%b want 000 0", s_sel, s_re); end
    vectors++; if (err_count !== 8'h01) begin miscompares++; $display("FAIL um_errcnt: got %h want 01", err_count); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL um_idle: got v=%b rdy=%b want 0 1", resp_valid, req_ready); end
  endtask

  // Data memory never acks; a stray ack from slave 2 must not end the access.
  task automatic test_timeout;
    int cnt = 0;
    bit got = 0;
    req_valid = 1; req_we = 0; req_addr = 32'h10; s_ack = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 0;
      if (resp_valid === 1'b1) got = 1;
      else begin
        if (s_re === 1'b1 && s_sel === 3'b001) cnt++;
        if (k == 3) s_ack = 3'b100;
        if (k == 4) s_ack = 3'b000;
      end
    end
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL to_noresp: got %b want 1", got); end
    vectors++; if (cnt != 15) begin miscompares++; $display("FAIL to_cycles: got %0d want 15", cnt); end
    vectors++; if (resp_err !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL to_resp: got e=%b d=%h want 1 deadbeef", resp_err, resp_rdata); end
    vectors++; if (err_count !== 8'h02) begin miscompares++; $display("FAIL to_errcnt: got %h want 02", err_count); end
    @(negedge clk);
  endtask

  // Ack on the final ACCESS cycle arrives with the timeout and must win.
  task automatic test_ack_timeout_race;
    req_valid = 1; req_we = 0; req_addr = 32'h10; s_rdata = {32'h0, 32'h0, 32'h1234}; s_ack = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 0;
      if (k == 15) s_ack = 3'b001;
    end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h1234) begin miscompares++; $display("FAIL race_resp: got v=%b e=%b d=%h want 1 0 00001234", resp_valid, resp_err, resp_rdata); end
    vectors++; if (err_count !== 8'h02) begin miscompares++; $display("FAIL race_errcnt: got %h want 02", err_count); end
    s_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 0;
    vectors++; if (s_re !== 1'b1 || s_sel !== 3'b001) begin miscompares++; $display("FAIL rm_access: got re=%b sel=%b want 1 001", s_re, s_sel); end
    #1 rst = 0;
    #1;
    vectors++; if (s_sel !== 3'b000 || s_re !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rm_async: got sel=%b re=%b rdy=%b want 000 0 1", s_sel, s_re, req_ready); end
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL rm_errcnt: got %h want 00", err_count); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rm_noresp: got %0d pulses want 0", seen); end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_saturate;
    int n = 0;
    req_valid = 1; req_we = 0; req_addr = 32'h2000;
    for (int k = 0; k < 1000 && n < 300; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        n++;
        if (n == 254) begin
          vectors++; if (err_count !== 8'hFE) begin miscompares++; $display("FAIL sat_254: got %h want fe", err_count); end
        end
        if (n == 255) begin
          vectors++; if (err_count !== 8'hFF) begin miscompares++; $display("FAIL sat_255: got %h want ff", err_count); end
        end
      end
    end
    req_valid = 0;
    vectors++; if (n != 300) begin miscompares++; $display("FAIL sat_count: got %0d responses want 300", n); end
    vectors++; if (err_count !== 8'hFF) begin miscompares++; $display("FAIL sat_hold: got %h want ff", err_count); end
    @(negedge clk);
  endtask

  // Held request: RESP cycle must not accept, the following IDLE edge does.
  task automatic test_back_to_back;
    req_valid = 1; req_we = 0; req_addr = 32'h404;
    s_rdata = {32'h0, 32'h5A5A, 32'h0}; s_ack = 3'b010;
    @(negedge clk);
    vectors++; if (s_sel !== 3'b010) begin miscompares++; $display("FAIL b2b_first: got %b want 010", s_sel); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h5A5A) begin miscompares++; $display("FAIL b2b_resp1: got v=%b d=%h want 1 00005a5a", resp_valid, resp_rdata); end
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1 || s_sel !== 3'b000 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got rdy=%b sel=%b v=%b want 1 000 0", req_ready, s_sel, resp_valid); end
    @(negedge clk);
    req_valid = 0;
    vectors++; if (s_sel !== 3'b010 || s_re !== 1'b1) begin miscompares++; $display("FAIL b2b_second: got sel=%b re=%b want 010 1", s_sel, s_re); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin miscompares++; $display("FAIL b2b_resp2: got v=%b e=%b want 1 0", resp_valid, resp_err); end
    s_ack = 0;
    @(negedge clk);
    vectors++; if (err_count !== 8'hFF) begin miscompares++; $display("FAIL b2b_errcnt: got %h want ff", err_count); end
  endtask

  initial begin
    test_reset();
    test_read_switch();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_ack_timeout_race();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
